uart_param_recv: RTL and testbench
==================================

# uart_param_recv

UART receiver for 8-bit, LSB-first, 1-stop-bit serial frames (8N1; 8E1 with parity enabled). It oversamples the asynchronous `rx` line with the system clock and delivers each received byte as a one-cycle `data_rdy` strobe. It uses the same bit-period definition as the team's UART transmitter, so the two form a loopback pair at the same `countOfStrobe`. It sits between the board RX pin and the byte-consuming logic.

## Interface
- `countOfStrobe`, default 865: bit period minus one, in clocks. One bit lasts `countOfStrobe+1` cycles. Legal range 4..65535.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx`  in  1  serial input, asynchronous to `clk`, idle high.
- `data`  out  8  last correctly framed byte; holds until the next good frame.
- `data_rdy`  out  1  one-cycle strobe; `data` is valid and new in this cycle.
- `frame_err`  out  1  one-cycle strobe; the stop bit was sampled low.
- `parity_err`  out  1  one-cycle strobe, coincident with `data_rdy`; the parity bit mismatched.
- `busy`  out  1  high while a frame is in progress (any state other than IDLE).

## Operation
- **Synchronizer:** `rx` passes through two flops to give `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- **Counter:** `cnt` is 16 bits. Let `H = countOfStrobe/2` (integer divide) and `N = countOfStrobe`.
- **IDLE:** when `rx_s == 0`, clear `cnt`, clear `bitn`, go to START.
- **START:** increment `cnt` each cycle. When `cnt == H`:
  - if `rx_s == 0`, clear `cnt` and go to DATA;
  - otherwise the start was a glitch: go to IDLE, no output.
- **DATA:** increment `cnt` each cycle. When `cnt == N`:
  - shift `rx_s` into bit 7 of the shift register (shift right), clear `cnt`, increment `bitn`;
  - after the 8th bit, go to PARITY if enabled, else STOP.
- **PARITY:** when `cnt == N`, capture `rx_s` as `pbit`, clear `cnt`, go to STOP.
- **STOP:** when `cnt == N`:
  - if `rx_s == 1`: load `data` from the shift register, pulse `data_rdy`, pulse `parity_err` if `^{shift,pbit} != 0`, go to IDLE;
  - if `rx_s == 0`: pulse `frame_err`, leave `data` unchanged, go to BREAK.
- **BREAK:** wait until `rx_s == 1`, then go to IDLE. This prevents a held-low line from retriggering.
- **Back-to-back frames:** return to IDLE happens at mid-stop-bit, so a start edge immediately after the stop bit is caught.
- **Reset:** `rst_n` low at any time, including mid-frame, asynchronously forces:
  - state IDLE, `cnt = 0`, `bitn = 0`, shift register = 0;
  - `data = 0`, `data_rdy = 0`, `frame_err = 0`, `parity_err = 0`, `busy = 0`.

## Timing
- **Start detection:** if `rx` falls before edge `t`, `rx_s` is low at edge `t+2`. START is entered at `t+3`.
- **Sample points:**
  - start check at `t+3+H`;
  - data bit k (k = 0..7) at `t+3+H+(k+1)(N+1)`;
  - parity at `t+3+H+9(N+1)`;
  - stop at `t+3+H+9(N+1)`, or `+10(N+1)` with parity.
- **Output latency:** `data_rdy` / `frame_err` / `parity_err` are registered and high for exactly the one cycle after the stop sample.
- **No back-pressure:** the consumer must take `data` while `data_rdy` is high. A following frame overwrites `data` at least 9 bit periods later.
- **Tolerance:** sampling is nominally mid-bit. Baud mismatch up to ±4% is tolerated at N ≥ 15.

## Configuration
- **`UART_RX_PARITY_EN` defined:** the PARITY state is present. The frame is 11 bits with even parity, and `parity_err` is live. A parity error still delivers `data` with `data_rdy`.
- **`UART_RX_PARITY_EN` undefined:** there is no PARITY state. The frame is 10 bits, and `parity_err` is tied to 0.

## Test plan
- **Single byte:** `countOfStrobe = 15`, send 0x55 (8N1, 16 clocks/bit) -> one `data_rdy` pulse with `data = 0x55` at the computed cycle; `frame_err = 0`; `busy` low afterwards.
- **Start glitch:** `rx` low for 3 cycles, then high -> no strobes; `busy` drops back within H+4 cycles; `data` unchanged.
- **Bad stop bit:** send 0xA5 with the stop bit forced low, then hold `rx` low for 40 cycles, then release -> exactly one `frame_err` pulse; `data` keeps its prior value; no new frame until `rx` returns high.
- **Back-to-back:** send 0xA5 then 0x3C with no idle gap -> two `data_rdy` pulses with 0xA5 then 0x3C, spaced 10×16 cycles.
- **Reset mid-frame:** assert `rst_n` low during data bit 4 of 0xFF, release, send 0x12 -> all outputs 0 during reset; next `data_rdy` carries 0x12.
- **Parity (`UART_RX_PARITY_EN`):** send 0x03 with parity 0 -> `data = 0x03`, `parity_err = 0`; send 0x03 with parity 1 -> `data_rdy` and `parity_err` pulse together.

Source files
------------

// File: rtl/uart_param_recv.sv
// 8-bit LSB-first UART receiver with mid-bit sampling and a two-flop rx synchronizer.
// Define UART_RX_PARITY_EN to add an even-parity bit (11-bit frames) and enable parity_err.
module uart_param_recv #(
    parameter int unsigned countOfStrobe = 865
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_rdy,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam logic [15:0] N = 16'(countOfStrobe);
    localparam logic [15:0] H = 16'(countOfStrobe / 2);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bitn_q, bitn_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        data_rdy_q, data_rdy_d;
    logic        frame_err_q, frame_err_d;
    logic        parity_err_q, parity_err_d;
    logic        busy_q, busy_d;
    logic        rx_s;
`ifdef UART_RX_PARITY_EN
    logic        pbit_q, pbit_d;
`endif

    assign sync_d = {sync_q[0], rx};
    assign rx_s   = sync_q[1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bitn_d       = bitn_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_rdy_d   = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbit_d       = pbit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    bitn_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                // Re-check the line half a bit in; a high here means the edge was a glitch.
                if (cnt_q == H) begin
                    cnt_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == N) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = '0;
                    bitn_d  = bitn_q + 3'd1;
                    if (bitn_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == N) begin
                    pbit_d  = rx_s;
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            S_STOP: begin
                // Leaving at mid-stop-bit lets a directly following start edge be caught.
                if (cnt_q == N) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d     = shift_q;
                        data_rdy_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = ^{shift_q, pbit_q};
`endif
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sync_q       <= 2'b11;
            cnt_q        <= '0;
            bitn_q       <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_rdy_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            bitn_q       <= bitn_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_rdy_q   <= data_rdy_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
            pbit_q       <= pbit_d;
`endif
        end
    end

    assign data       = data_q;
    assign data_rdy   = data_rdy_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_uart_param_recv.sv
// Directed bench for uart_param_recv at countOfStrobe = 15 (16 clocks per bit).
// Build with UART_RX_PARITY_EN defined to also cover the even-parity frame format.
module tb_uart_param_recv;
    localparam int CS  = 15;
    localparam int BIT = CS + 1;
    localparam int H   = CS / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    // Cycles from the first edge after the start bit is driven to the strobe cycle:
    // start seen at t+2, stop sampled at t+3+H+(9 or 10)*BIT, strobe one cycle later.
    localparam int LAT = 3 + H + (PAR ? 10 : 9) * BIT + 1;
    localparam int FRAME = (PAR ? 11 : 10) * BIT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       data_rdy, frame_err, parity_err, busy;

    uart_param_recv #(.countOfStrobe(CS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .data_rdy   (data_rdy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rdy_data_q[$];
    int         rdy_cyc_q[$];
    int         fe_cyc_q[$];
    int         pe_cyc_q[$];
    int         pe_total = 0;
    bit         busy_seen = 1'b0;

    always @(negedge clk) begin
        if (data_rdy) begin
            rdy_data_q.push_back(data);
            rdy_cyc_q.push_back(cyc);
        end
        if (frame_err) fe_cyc_q.push_back(cyc);
        if (parity_err) begin
            pe_cyc_q.push_back(cyc);
            pe_total++;
        end
        if (busy) busy_seen = 1'b1;
    end

    int vectors = 0;
    int miscompares = 0;
    int base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic pbit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        if (PAR) send_bit(pbit);
        send_bit(stop_v);
    endtask

    task automatic clear_logs();
        rdy_data_q.delete();
        rdy_cyc_q.delete();
        fe_cyc_q.delete();
        pe_cyc_q.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_data", 32'(data), 32'h00);
        check("reset_rdy", 32'(data_rdy), 32'h0);
        check("reset_ferr", 32'(frame_err), 32'h0);
        check("reset_perr", 32'(parity_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single byte 0x55
        clear_logs();
        base = cyc;
        send_frame(8'h55, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("single_count", 32'(rdy_data_q.size()), 32'd1);
        check("single_byte", 32'(rdy_data_q[0]), 32'h55);
        check("single_latency", 32'(rdy_cyc_q[0] - base), 32'(LAT));
        check("single_ferr", 32'(fe_cyc_q.size()), 32'd0);
        check("single_busy_after", 32'(busy), 32'h0);
        check("single_data_hold", 32'(data), 32'h55);

        // Start glitch: 3 low cycles
        clear_logs();
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (H + 6) @(negedge clk);
        check("glitch_busy_seen", 32'(busy_seen), 32'h1);
        check("glitch_busy_drop", 32'(busy), 32'h0);
        check("glitch_no_rdy", 32'(rdy_data_q.size()), 32'd0);
        check("glitch_no_ferr", 32'(fe_cyc_q.size()), 32'd0);
        check("glitch_data", 32'(data), 32'h55);

        // Bad stop bit on 0xA5, then line held low for 40 cycles
        clear_logs();
        base = cyc;
        send_frame(8'hA5, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("badstop_ferr_count", 32'(fe_cyc_q.size()), 32'd1);
        check("badstop_ferr_time", 32'(fe_cyc_q[0] - base), 32'(LAT));
        check("badstop_no_rdy", 32'(rdy_data_q.size()), 32'd0);
        check("badstop_data_kept", 32'(data), 32'h55);
        check("badstop_busy_held", 32'(busy), 32'h1);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        check("badstop_busy_release", 32'(busy), 32'h0);
        check("badstop_no_retrigger", 32'(rdy_data_q.size() + fe_cyc_q.size()), 32'd1);

        // Back-to-back 0xA5, 0x3C
        clear_logs();
        base = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("b2b_count", 32'(rdy_data_q.size()), 32'd2);
        check("b2b_first", 32'(rdy_data_q[0]), 32'hA5);
        check("b2b_second", 32'(rdy_data_q[1]), 32'h3C);
        check("b2b_first_latency", 32'(rdy_cyc_q[0] - base), 32'(LAT));
        check("b2b_spacing", 32'(rdy_cyc_q[1] - rdy_cyc_q[0]), 32'(FRAME));
        check("b2b_data", 32'(data), 32'h3C);

        // Reset asserted in the middle of data bit 4 of 0xFF
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BIT + BIT / 2) @(negedge clk);
        check("midrst_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_rdy", 32'(data_rdy), 32'h0);
        check("midrst_ferr", 32'(frame_err), 32'h0);
        check("midrst_perr", 32'(parity_err), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        clear_logs();
        base = cyc;
        send_frame(8'h12, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("postrst_count", 32'(rdy_data_q.size()), 32'd1);
        check("postrst_byte", 32'(rdy_data_q[0]), 32'h12);
        check("postrst_latency", 32'(rdy_cyc_q[0] - base), 32'(LAT));

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x03 has two ones, so parity bit 0 is correct
        clear_logs();
        send_frame(8'h03, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("par_ok_count", 32'(rdy_data_q.size()), 32'd1);
        check("par_ok_byte", 32'(rdy_data_q[0]), 32'h03);
        check("par_ok_perr", 32'(pe_cyc_q.size()), 32'd0);
        clear_logs();
        send_frame(8'h03, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("par_bad_count", 32'(rdy_data_q.size()), 32'd1);
        check("par_bad_byte", 32'(rdy_data_q[0]), 32'h03);
        check("par_bad_perr", 32'(pe_cyc_q.size()), 32'd1);
        check("par_bad_coincident", 32'(pe_cyc_q[0]), 32'(rdy_cyc_q[0]));
`else
        check("noparity_perr_total", 32'(pe_total), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
